alu_operand_issue: RTL and testbench
====================================

// Module: alu_operand_issue
// PURPOSE
//  Issue stage directly upstream of the 32-bit ALU. Accepts decoded ops, reads
//  operands from an internal register file, and tracks in-flight destinations
//  with a scoreboard, stalling on RAW/WAW hazards. Presents a registered
//  {A, B, Op, shift, rd} bundle to the ALU under a valid/ready handshake.
//  Writeback from the downstream stage returns through the wb_* port.
// PARAMETERS
//  DATA_W    32  operand/register width
//  REG_AW    5   register address width (2**REG_AW registers; R0 reads zero)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       decoded op present
//  in_ready   out  1       op accepted this cycle when in_valid & in_ready
//  in_op      in   4       ALU opcode (alu_pkg encodings)
//  in_rs1     in   REG_AW  source for A
//  in_rs2     in   REG_AW  source for B (ignored when in_use_imm)
//  in_rd      in   REG_AW  destination (0 = no writeback)
//  in_use_imm in   1       B <- in_imm instead of R[rs2]
//  in_imm     in   DATA_W  immediate
//  in_shift   in   5       shift amount, passed through
//  out_valid  out  1       bundle valid to ALU
//  out_ready  in   1       ALU/next stage takes bundle
//  out_a      out  DATA_W  operand A
//  out_b      out  DATA_W  operand B
//  out_op     out  4       opcode
//  out_shift  out  5       shift amount
//  out_rd     out  REG_AW  destination tag
//  wb_en      in   1       writeback strobe
//  wb_addr    in   REG_AW  writeback register
//  wb_data    in   DATA_W  writeback value
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0; out_a/b/op/shift/rd=0; all pending
//    bits=0; register file all zero. in_ready low while rst_n=0.
//  - hazard = pend[rs1] | (!in_use_imm & pend[rs2]) | pend[rd]; pend[0] always 0.
//  - in_ready = (!out_valid | out_ready) & !hazard. Purely combinational.
//  - Issue (in_valid & in_ready): output regs load next edge; out_valid=1;
//    pend[rd] set if rd!=0. Latency: input to out_valid = 1 cycle.
//  - out_valid & out_ready & no issue: out_valid clears. Bundle held stable
//    while out_valid & !out_ready.
//  - wb_en: R[wb_addr] <= wb_data and pend[wb_addr] cleared on the same edge;
//    wb_addr=0 ignored. Same-edge set (issue) and clear (wb) of one register:
//    set wins.
//  - Reads of R0 return 0. out_op unchanged for unused codes (ALU yields 0).
//  - Arithmetic: none; widths passed unmodified.
// CONFIGURATION
//  ALU_ISSUE_BYPASS_EN defined: wb port bypasses into the read path and the
//    hazard check -- a source whose pend bit is being cleared by wb this cycle
//    is not a hazard, and its operand is wb_data (0-cycle writeback-to-issue).
//  Undefined: hazard uses registered pend only; a dependent op issues the
//    cycle after wb (1 extra stall cycle). Results identical, timing differs.
// STRUCTURE
//  - alu_pkg: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLL=4, OP_SRL=5,
//    OP_XNOR=6, OP_EQ=7, OP_LT=8, OP_GT=9, OP_XOR=10, OP_SLLEQ=11, OP_BEQ8=12,
//    OP_RSB=13, OP_NOT=14; DATA_W/REG_AW defaults. Shared with the ALU.
//  - Sub-module regfile_2r1w: 2 async read, 1 sync write, R0=0, async clear.
//  - Scoreboard and output register stay in this module.
// TESTING
//  1 Reset mid-issue: rst_n low while out_valid=1 -> out_valid=0, pend=0 next
//    sample, R5 reads 0 after reset.
//  2 wb R1=5,R2=7; issue ADD rs1=1 rs2=2 rd=3 -> next cycle out_a=5, out_b=7,
//    out_op=0, out_rd=3, pend[3]=1.
//  3 RAW: issue rd=3 then rs1=3 -> in_ready=0 until wb R3=12; with BYPASS_EN
//    issues in wb cycle with out_a=12; without, issues the following cycle.
//  4 Backpressure: out_ready=0 three cycles -> bundle stable, in_ready=0, no
//    second issue; out_ready=1 -> queued op issues same edge as handoff.
//  5 Immediate/R0: in_use_imm=1, imm=0xFFFF_FFFF, rs2 pending -> no stall,
//    out_b=0xFFFF_FFFF; rs1=0 -> out_a=0; rd=0 sets no pend; wb R0 ignored.
//  6 Same-edge issue rd=4 and wb R4 -> pend[4]=1 afterwards, R4=wb_data.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and default widths shared by the issue stage and the ALU.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_REG_AW = 5;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLL   = 4'd4,
        OP_SRL   = 4'd5,
        OP_XNOR  = 4'd6,
        OP_EQ    = 4'd7,
        OP_LT    = 4'd8,
        OP_GT    = 4'd9,
        OP_XOR   = 4'd10,
        OP_SLLEQ = 4'd11,
        OP_BEQ8  = 4'd12,
        OP_RSB   = 4'd13,
        OP_NOT   = 4'd14
    } alu_op_e;

endpackage

// File: rtl/alu_operand_issue_regfile_2r1w.sv
// regfile_2r1w: two asynchronous read ports, one synchronous write port.
// Register 0 is hardwired to zero; writes to it are dropped.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREG = 1 << AW;

    logic [DATA_W-1:0] mem [NREG];

    // Storage: cleared asynchronously, written on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: R0 forced to zero regardless of array contents.
    always_comb begin
        rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
        rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
    end

endmodule

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: operand read + scoreboard issue stage in front of the ALU.
// Optional macro ALU_ISSUE_BYPASS_EN: writeback data forwards into the operand
// read and clears source hazards in the same cycle. Without it a dependent op
// waits one extra cycle for the register file write to land.
module alu_operand_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [4:0]        in_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [3:0]        out_op,
    output logic [4:0]        out_shift,
    output logic [REG_AW-1:0] out_rd,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_next;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              busy_rs1;
    logic              busy_rs2;
    logic              hazard;
    logic              issue;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .AW     (REG_AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (in_rs1),
        .rdata_a (rf_a),
        .raddr_b (in_rs2),
        .rdata_b (rf_b)
    );

`ifdef ALU_ISSUE_BYPASS_EN
    logic wb_hit_rs1;
    logic wb_hit_rs2;

    // Forwarding: a source being written back this cycle is ready and takes wb_data.
    always_comb begin
        wb_hit_rs1 = wb_en && (wb_addr == in_rs1) && (in_rs1 != '0);
        wb_hit_rs2 = wb_en && (wb_addr == in_rs2) && (in_rs2 != '0);
        busy_rs1   = pend[in_rs1] && !wb_hit_rs1;
        busy_rs2   = pend[in_rs2] && !wb_hit_rs2;
        opnd_a     = wb_hit_rs1 ? wb_data : rf_a;
        opnd_b     = wb_hit_rs2 ? wb_data : rf_b;
    end
`else
    // No forwarding: hazards come from registered pend bits, operands from the file.
    always_comb begin
        busy_rs1 = pend[in_rs1];
        busy_rs2 = pend[in_rs2];
        opnd_a   = rf_a;
        opnd_b   = rf_b;
    end
`endif

    // Handshake: stall on RAW/WAW or when the output register cannot be refilled.
    always_comb begin
        hazard   = busy_rs1 || (!in_use_imm && busy_rs2) || pend[in_rd];
        in_ready = rst_n && (!out_valid || out_ready) && !hazard;
        issue    = in_valid && in_ready;
    end

    // Scoreboard next state: writeback clears first, issue sets after, so set wins.
    always_comb begin
        pend_next = pend;
        if (wb_en) pend_next[wb_addr] = 1'b0;
        if (issue) pend_next[in_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_next;
    end

    // Output bundle register: loads on issue, holds while the ALU back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            out_shift <= '0;
            out_rd    <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_a     <= opnd_a;
            out_b     <= in_use_imm ? in_imm : opnd_b;
            out_op    <= in_op;
            out_shift <= in_shift;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
// tb_alu_operand_issue: directed scenarios plus randomized traffic, checked
// against an architectural model (register array, pending set, output slot).
module tb_alu_operand_issue;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [4:0]  in_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_op;
    logic [4:0]  out_shift;
    logic [4:0]  out_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    alu_operand_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .in_shift   (in_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_op     (out_op),
        .out_shift  (out_shift),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- architectural model ----------------
    logic [31:0] m_reg [32];
    bit          m_pend [32];
    bit          m_ov;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_shift, m_rd;

    function automatic bit src_busy(input logic [4:0] r);
        bool_wb_hit: begin end
        return m_pend[r] && !(BYP && wb_en && wb_addr == r && r != 0);
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (BYP && wb_en && wb_addr == r) return wb_data;
        return m_reg[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_ov = 0; m_a = 0; m_b = 0; m_op = 0; m_shift = 0; m_rd = 0;
    endtask

    // Compare at the falling edge, then advance the model across the next rising edge.
    initial begin : compare
        logic [31:0] n_reg [32];
        bit          n_pend [32];
        bit          n_ov;
        logic [31:0] n_a, n_b;
        logic [3:0]  n_op;
        logic [4:0]  n_shift, n_rd;
        bit          hz, rdy, iss;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
                continue;
            end
            hz  = src_busy(in_rs1) || (!in_use_imm && src_busy(in_rs2)) || m_pend[in_rd];
            rdy = (!m_ov || out_ready) && !hz;
            chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            if (m_ov) begin
                chk("out_a", out_a, m_a);
                chk("out_b", out_b, m_b);
                chk("out_op", {28'd0, out_op}, {28'd0, m_op});
                chk("out_shift", {27'd0, out_shift}, {27'd0, m_shift});
                chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
            end
            iss = in_valid && rdy;
            n_reg = m_reg; n_pend = m_pend;
            n_ov = m_ov; n_a = m_a; n_b = m_b; n_op = m_op; n_shift = m_shift; n_rd = m_rd;
            if (wb_en && wb_addr != 0) begin
                n_reg[wb_addr]  = wb_data;
                n_pend[wb_addr] = 1'b0;
            end
            if (iss) begin
                if (in_rd != 0) n_pend[in_rd] = 1'b1;
                n_ov = 1; n_a = src_val(in_rs1);
                n_b = in_use_imm ? in_imm : src_val(in_rs2);
                n_op = in_op; n_shift = in_shift; n_rd = in_rd;
            end else if (out_ready) begin
                n_ov = 0;
            end
            @(posedge clk);
            if (rst_n) begin
                m_reg = n_reg; m_pend = n_pend;
                m_ov = n_ov; m_a = n_a; m_b = n_b; m_op = n_op; m_shift = n_shift; m_rd = n_rd;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_use_imm = 0; in_imm = 0; in_shift = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic op(input logic [3:0] o, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] d);
        in_valid = 1; in_op = o; in_rs1 = r1; in_rs2 = r2; in_rd = d;
        in_use_imm = 0; in_imm = 0; in_shift = 5'd3;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    initial begin : stim
        rst_n = 0;
        idle();
        repeat (3) cyc();
        rst_n = 1;
        cyc();

        // writeback then a plain ADD
        wb(1, 32'd5); cyc();
        wb(2, 32'd7); cyc();
        wb_en = 0;
        op(4'd0, 1, 2, 3); #1;
        chk("t2_ready", {31'd0, in_ready}, 32'd1);
        cyc(); in_valid = 0;
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_a", out_a, 32'd5);
        chk("t2_b", out_b, 32'd7);
        chk("t2_op", {28'd0, out_op}, 32'd0);
        chk("t2_rd", {27'd0, out_rd}, 32'd3);
        chk("t2_shift", {27'd0, out_shift}, 32'd3);

        // RAW on R3
        op(4'd1, 3, 0, 6); #1;
        chk("t3_stall0", {31'd0, in_ready}, 32'd0);
        cyc();
        chk("t3_stall1", {31'd0, in_ready}, 32'd0);
        wb(3, 32'd12); #1;
        chk("t3_wb_cycle", {31'd0, in_ready}, {31'd0, BYP});
        cyc(); wb_en = 0;
        if (!BYP) begin
            #1;
            chk("t3_after_wb", {31'd0, in_ready}, 32'd1);
            cyc();
        end
        in_valid = 0;
        chk("t3_a", out_a, 32'd12);
        chk("t3_rd", {27'd0, out_rd}, 32'd6);
        wb(6, 32'd1); cyc(); wb_en = 0;

        // back-pressure
        out_ready = 0;
        op(4'd2, 1, 2, 7); cyc();
        op(4'd3, 2, 1, 8);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_hold_ready", {31'd0, in_ready}, 32'd0);
            chk("t4_hold_a", out_a, 32'd5);
            chk("t4_hold_op", {28'd0, out_op}, 32'd2);
            cyc();
        end
        out_ready = 1; #1;
        chk("t4_release", {31'd0, in_ready}, 32'd1);
        cyc(); in_valid = 0;
        chk("t4_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_op", {28'd0, out_op}, 32'd3);
        chk("t4_a", out_a, 32'd7);
        cyc();

        // immediate with pending rs2, R0 source, rd=0
        op(4'd14, 0, 7, 0); in_use_imm = 1; in_imm = 32'hFFFF_FFFF; #1;
        chk("t5_no_stall", {31'd0, in_ready}, 32'd1);
        cyc(); in_valid = 0;
        chk("t5_b", out_b, 32'hFFFF_FFFF);
        chk("t5_a", out_a, 32'd0);
        wb(0, 32'd99); cyc(); wb_en = 0;
        op(4'd0, 0, 0, 0); cyc(); in_valid = 0;
        chk("t5_r0_a", out_a, 32'd0);
        chk("t5_r0_b", out_b, 32'd0);
        wb(7, 32'd70); cyc();
        wb(8, 32'd80); cyc(); wb_en = 0;

        // same-edge issue rd=4 and writeback R4
        op(4'd0, 1, 2, 4); wb(4, 32'd44); cyc();
        in_valid = 0; wb_en = 0;
        op(4'd0, 4, 0, 9); #1;
        chk("t6_pend4", {31'd0, in_ready}, 32'd0);
        in_valid = 0; wb(4, 32'd46); cyc(); wb_en = 0;
        op(4'd0, 4, 0, 0); cyc(); in_valid = 0;
        chk("t6_r4", out_a, 32'd46);

        // reset with a bundle in flight
        wb(5, 32'd55); cyc(); wb_en = 0;
        out_ready = 0;
        op(4'd0, 1, 1, 5); cyc(); in_valid = 0;
        chk("t1_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 0; #1;
        chk("t1_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        rst_n = 1; out_ready = 1;
        op(4'd0, 5, 5, 9); #1;
        chk("t1_pend_clr", {31'd0, in_ready}, 32'd1);
        cyc(); in_valid = 0;
        chk("t1_r5_a", out_a, 32'd0);
        chk("t1_r5_b", out_b, 32'd0);
        cyc();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_op      = 4'($urandom_range(0, 15));
            in_rs1     = 5'($urandom_range(0, 7));
            in_rs2     = 5'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 7));
            in_use_imm = $urandom_range(0, 1) == 1;
            in_imm     = $urandom;
            in_shift   = 5'($urandom_range(0, 31));
            out_ready  = ($urandom_range(0, 3) != 0);
            wb_en      = ($urandom_range(0, 9) < 4);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            cyc();
        end
        idle();
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
